// File: rtl/data_mem_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_stage_if : EX/MEM request bus and MEM/WB result bus             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface data_mem_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        mem_stall;
  logic        misaligned;

  modport master (
    output mem_read, mem_write, funct3, addr, write_data,
    input  read_data, mem_stall, misaligned
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, write_data,
    output read_data, mem_stall, misaligned
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_stage : multi-cycle byte-addressed RV64 load/store stage        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module data_mem_stage #(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  data_mem_stage_if.slave   bus
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              store_q,     store_d;
  logic [1:0]        size_q,      size_d;
  logic              zext_q,      zext_d;
  logic [AW-1:0]     idx_q,       idx_d;
  logic [63:0]       wdata_q,     wdata_d;
  logic [63:0]       read_data_q, read_data_d;

  logic [7:0]        mem_array [DEPTH_BYTES];

  logic              w_req;
  logic [2:0]        w_align_mask;
  logic              w_addr_misaligned;
  logic              w_in_idle;
  logic              w_accept;
  logic              w_complete;
  logic              w_cur_store;
  logic [1:0]        w_cur_size;
  logic              w_cur_zext;
  logic [AW-1:0]     w_cur_idx;
  logic [63:0]       w_cur_wdata;
  logic [7:0]        w_be;
  logic [63:0]       w_raw;
  logic [63:0]       w_load_ext;
  logic              w_mem_we;
  logic              w_unused_addr;

  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_in_idle = (state_q == IDLE);

  always_comb begin
    w_align_mask = 3'b000;
    case (bus.funct3[1:0])
      2'd0:    w_align_mask = 3'b000;
      2'd1:    w_align_mask = 3'b001;
      2'd2:    w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
  end

  assign w_addr_misaligned = |(bus.addr[2:0] & w_align_mask);
  assign w_accept          = w_in_idle & w_req & ~w_addr_misaligned;

  assign bus.misaligned = w_in_idle & w_req & w_addr_misaligned;
  assign bus.mem_stall  = w_accept | (state_q == BUSY);
  assign bus.read_data  = read_data_q;

  // With LATENCY=1 the access completes on the accepting edge, so it must see the live request.
  assign w_cur_store = w_in_idle ? bus.mem_write        : store_q;
  assign w_cur_size  = w_in_idle ? bus.funct3[1:0]      : size_q;
  assign w_cur_zext  = w_in_idle ? bus.funct3[2]        : zext_q;
  assign w_cur_idx   = w_in_idle ? bus.addr[AW-1:0]     : idx_q;
  assign w_cur_wdata = w_in_idle ? bus.write_data       : wdata_q;

  assign w_unused_addr = ^bus.addr[63:AW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            state_d    = DONE;
            w_complete = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          w_complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    store_d = store_q;
    size_d  = size_q;
    zext_d  = zext_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    if (w_accept) begin
      store_d = bus.mem_write;
      size_d  = bus.funct3[1:0];
      zext_d  = bus.funct3[2];
      idx_d   = bus.addr[AW-1:0];
      wdata_d = bus.write_data;
    end
  end

  always_comb begin
    w_be = 8'h00;
    case (w_cur_size)
      2'd0:    w_be = 8'h01;
      2'd1:    w_be = 8'h03;
      2'd2:    w_be = 8'h0F;
      default: w_be = 8'hFF;
    endcase
  end

  // Byte offsets wrap naturally in the AW-bit index sum.
  always_comb begin
    w_raw = '0;
    for (int k = 0; k < 8; k++) begin
      w_raw[8*k +: 8] = mem_array[w_cur_idx + AW'(k)];
    end
  end

  always_comb begin
    w_load_ext = w_raw;
    case (w_cur_size)
      2'd0:    w_load_ext = w_cur_zext ? {56'b0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      2'd1:    w_load_ext = w_cur_zext ? {48'b0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      2'd2:    w_load_ext = w_cur_zext ? {32'b0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      default: w_load_ext = w_raw;
    endcase
  end

  always_comb begin
    read_data_d = read_data_q;
    if (w_complete && !w_cur_store) begin
      read_data_d = w_load_ext;
    end
  end

  assign w_mem_we = w_complete & w_cur_store & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      size_q      <= 2'd0;
      zext_q      <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      size_q      <= size_d;
      zext_q      <= zext_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  // Memory contents survive reset; only the in-flight store is dropped.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (w_be[k]) begin
          mem_array[w_cur_idx + AW'(k)] <= w_cur_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_stage : randomized + directed bench, LATENCY=2 and LATENCY=1 |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_data_mem_stage;

  localparam int DEPTH = 512;

  logic clk;
  logic reset;

  data_mem_stage_if bus0 ();
  data_mem_stage_if bus1 ();

  data_mem_stage #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  data_mem_stage #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ref_mem [2][DEPTH];
  logic [63:0] ref_rd  [2];
  int          lat     [2] = '{2, 1};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_rd(input int sel);
    return (sel == 1) ? bus1.read_data : bus0.read_data;
  endfunction

  function automatic logic get_stall(input int sel);
    return (sel == 1) ? bus1.mem_stall : bus0.mem_stall;
  endfunction

  function automatic logic get_mis(input int sel);
    return (sel == 1) ? bus1.misaligned : bus0.misaligned;
  endfunction

  task automatic idle_bus();
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.funct3 = 3'd0;
    bus0.addr = '0; bus0.write_data = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.funct3 = 3'd0;
    bus1.addr = '0; bus1.write_data = '0;
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    idle_bus();
    if (sel == 1) begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.funct3 = f3;
      bus1.addr = a; bus1.write_data = wd;
    end else begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.funct3 = f3;
      bus0.addr = a; bus0.write_data = wd;
    end
  endtask

  // One complete access; entered and left at 1 time unit after a rising edge.
  task automatic access(input int sel, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd);
    int          nb;
    int          idx;
    int          n;
    bit          mis;
    logic [63:0] v;
    nb  = 1 << f3[1:0];
    mis = (a % 64'(nb)) != 0;
    idx = int'(a % 64'(DEPTH));
    drive(sel, rd, wr, f3, a, wd);
    #1;
    check_val("misaligned", 64'(get_mis(sel)), 64'(mis));
    if (mis) begin
      check_val("stall_misaligned", 64'(get_stall(sel)), 64'd0);
      @(posedge clk); #1;
      idle_bus();
      check_val("rd_hold_misaligned", get_rd(sel), ref_rd[sel]);
      return;
    end
    n = 0;
    while (get_stall(sel) && n < 16) begin
      n++;
      @(posedge clk); #1;
    end
    check_val("stall_cycles", 64'(n), 64'(lat[sel]));
    if (wr) begin
      for (int k = 0; k < nb; k++) ref_mem[sel][(idx + k) % DEPTH] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < nb; k++) v |= 64'(ref_mem[sel][(idx + k) % DEPTH]) << (8 * k);
      if (!f3[2] && nb < 8 && v[8*nb-1]) v |= {64{1'b1}} << (8 * nb);
      ref_rd[sel] = v;
    end
    check_val("read_data_done", get_rd(sel), ref_rd[sel]);
    idle_bus();
    @(posedge clk); #1;
    check_val("stall_after_done", 64'(get_stall(sel)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sel;
    int          r;
    logic [63:0] a;
    logic [2:0]  f3;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[s][i] = 8'h00;
      ref_rd[s] = '0;
    end

    idle_bus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_val("reset_read_data", get_rd(s), 64'd0);
      check_val("reset_stall", 64'(get_stall(s)), 64'd0);
      check_val("reset_misaligned", 64'(get_mis(s)), 64'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed sequence on the LATENCY=2 instance.
    access(0, 0, 1, 3'b011, 64'h10, 64'h8877665544332211);
    access(0, 1, 0, 3'b011, 64'h10, 64'h0);
    check_val("ld_0x10", get_rd(0), 64'h8877665544332211);
    access(0, 1, 0, 3'b000, 64'h17, 64'h0);
    check_val("lb_0x17", get_rd(0), 64'hFFFFFFFFFFFFFF88);
    access(0, 1, 0, 3'b100, 64'h17, 64'h0);
    check_val("lbu_0x17", get_rd(0), 64'h0000000000000088);
    access(0, 1, 0, 3'b001, 64'h16, 64'h0);
    check_val("lh_0x16", get_rd(0), 64'hFFFFFFFFFFFF8877);
    access(0, 1, 0, 3'b110, 64'h14, 64'h0);
    check_val("lwu_0x14", get_rd(0), 64'h0000000088776655);
    access(0, 0, 1, 3'b010, 64'h13, 64'hDEADBEEF);
    access(0, 1, 0, 3'b011, 64'h10, 64'h0);
    check_val("ld_after_misaligned", get_rd(0), 64'h8877665544332211);
    access(0, 1, 1, 3'b000, 64'h10, 64'hAA);
    check_val("rd_after_both", get_rd(0), 64'h8877665544332211);
    access(0, 1, 0, 3'b011, 64'h10, 64'h0);
    check_val("ld_after_sb", get_rd(0), 64'h88776655443322AA);

    // Reset while the store is in BUSY.
    drive(0, 0, 1, 3'b011, 64'h20, 64'h1);
    #1;
    check_val("stall_idle_req", 64'(get_stall(0)), 64'd1);
    @(posedge clk); #1;
    check_val("stall_busy", 64'(get_stall(0)), 64'd1);
    reset = 1'b1;
    idle_bus();
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("rst_mid_stall", 64'(get_stall(0)), 64'd0);
    check_val("rst_mid_read_data", get_rd(0), 64'd0);
    check_val("rst_other_read_data", get_rd(1), 64'd0);
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    access(0, 1, 0, 3'b011, 64'h20, 64'h0);
    check_val("ld_0x20_dropped", get_rd(0), 64'd0);

    // Address wrap on both latencies.
    for (int s = 0; s < 2; s++) begin
      access(s, 0, 1, 3'b011, 64'(DEPTH + 8), 64'h0102030405060708);
      access(s, 1, 0, 3'b011, 64'h8, 64'h0);
      check_val("wrap_ld", get_rd(s), 64'h0102030405060708);
    end

    // Randomized traffic across both instances.
    for (int i = 0; i < 240; i++) begin
      sel = int'($urandom_range(0, 1));
      r   = int'($urandom_range(1, 3));
      f3  = 3'($urandom_range(0, 7));
      a   = 64'($urandom_range(0, 2 * DEPTH + 40));
      if ($urandom_range(0, 3) == 0) a[63:32] = $urandom;
      access(sel, r[0], r[1], f3, a, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_stage.md
# data_mem_stage

Multi-cycle data-memory stage between the EX/MEM pipeline register and the MEM/WB pipeline register of the 64-bit RISC-V core. It takes load/store requests from EX/MEM and performs byte-addressed, little-endian accesses of 1/2/4/8 bytes with RV64 sign/zero extension. It holds the pipeline through `mem_stall` for a fixed access latency, then presents the load result to MEM/WB's `read_data` input.

## Interface
- `DEPTH_BYTES`, 512, memory size in bytes; power of two, ≥ 8.
- `LATENCY`, 2, stall cycles per access; ≥ 1.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `funct3`  in  3  access size/extension (RV64 load/store encoding).
- `addr`  in  64  byte address (ALU result).
- `write_data`  in  64  store data; low bytes used.
- `read_data`  out  64  registered, extended load result; feeds MEM/WB.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- `misaligned`  out  1  request address not size-aligned; access suppressed.

## Operation
- FSM states: IDLE, BUSY, DONE. Down-counter `cnt` is sized for LATENCY-1.
- req = `mem_read | mem_write`. Both asserted: treated as a store; `read_data` is unchanged.
- Size: `funct3[1:0]` gives 1/2/4/8 bytes. Loads: 000 lb, 001 lh, 010 lw, 011 ld (sign-extend); 100 lbu, 101 lhu, 110 lwu (zero-extend). Load 111 is handled as ld. Stores ignore `funct3[2]`.
- `misaligned` = req & (addr mod size ≠ 0), combinational, IDLE only. A misaligned request causes no stall, no memory change and no `read_data` change. The FSM stays in IDLE.
- IDLE, aligned req:
  - Capture op, size, extension, index = `addr[log2(DEPTH_BYTES)-1:0]`, and `write_data`.
  - Go to BUSY with cnt = LATENCY-2 if LATENCY ≥ 2.
  - Go directly to DONE if LATENCY = 1.
- BUSY: if cnt = 0, go to DONE; else decrement cnt.
- Transition into DONE:
  - A store commits its bytes at that edge, LSB at the index.
  - A load registers its extended result into `read_data` at that edge.
- DONE: go to IDLE unconditionally. The request still visible in DONE is the one just serviced (EX/MEM was frozen), so it is ignored.
- Address wrap: any index + byte offset is taken modulo DEPTH_BYTES.
- `read_data` holds its value until the next completed load.

## Timing
- `mem_stall` = (IDLE & req & ~misaligned) | BUSY. It is combinational in IDLE so the same-cycle EX/MEM value is held. It is 0 in DONE.
- An aligned access stalls for exactly LATENCY cycles. The pipeline advances at the end of the DONE cycle.
- Load data is valid in `read_data` from the DONE cycle onward, which is the cycle MEM/WB captures it.
- Back-to-back accesses: a new request is first seen in the IDLE cycle after DONE. Minimum spacing is LATENCY+1 cycles per access.
- Reset values: state IDLE, cnt 0, `read_data` 0, `mem_stall` 0, `misaligned` 0 (with no request present).
- Reset mid-access (BUSY or DONE): return to IDLE next edge. A pending store is dropped and `read_data` is cleared. Reset takes priority over everything.
- Reset does not clear memory contents. Contents are zero at time 0 only.

## Test plan
- Reset, then sd 0x8877665544332211 to addr 0x10 with LATENCY=2: `mem_stall` high for 2 cycles, low in DONE. Then ld at 0x10 returns 0x8877665544332211 in its DONE cycle.
- lb / lbu at 0x17: 0xFFFFFFFFFFFFFF88 / 0x0000000000000088. lh at 0x16: 0xFFFFFFFFFFFF8877. lwu at 0x14: 0x0000000088776655.
- sw 0xDEADBEEF at 0x13: `misaligned`=1, `mem_stall`=0, no state change. A following ld at 0x10 is unchanged.
- `mem_read` and `mem_write` together, sb 0xAA at 0x10: memory byte becomes 0xAA, `read_data` unchanged. A subsequent ld at 0x10 returns 0x88776655443322AA.
- Assert reset in BUSY of sd 0x1 to 0x20: FSM in IDLE and `mem_stall`=0 next cycle, `read_data`=0. ld at 0x20 returns 0.
- Address wrap: sd 0x0102030405060708 at DEPTH_BYTES+8 (0x208), then ld at 0x8 returns 0x0102030405060708. Repeat with LATENCY=1: 1-cycle stall.
